// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: each channel toggles clk_out every
// 'act' cycles, with glitch-free shadowed divisor updates and a global sync restart.
module clk_divider_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 50_000_000,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_div,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                sync,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] act;
        logic [WIDTH-1:0] shd;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] eff;
        logic             pend;
        logic             out_q;
        logic             tick_q;
        logic             wrap;
        logic             hit;

        // NOTE: every signal is assigned on every pass, so no latch is inferred.
        always_comb begin
            eff  = (act == '0) ? WIDTH'(1) : act;
            // ">=" rather than "==" so a divisor lowered below cnt still wraps.
            wrap = (cnt >= eff - 1'b1);
            // Matching a channel index below CHANNELS implicitly drops out-of-range writes.
            hit  = wr_en && (wr_ch == CH_W'(i));
        end

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                // NOTE: act/shd are small flop banks, not RAM, so they take a reset value.
                act    <= RESET_DIV;
                shd    <= RESET_DIV;
                cnt    <= '0;
                pend   <= 1'b0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (sync) begin
                cnt    <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
                pend   <= 1'b0;
                if (hit) begin
                    act <= wr_div;
                    shd <= wr_div;
                end else if (pend) begin
                    act <= shd;
                end
            end else if (!ch_en[i]) begin
                tick_q <= 1'b0;
                if (hit) begin
                    act  <= wr_div;
                    shd  <= wr_div;
                    pend <= 1'b0;
                end
            end else begin
                if (wrap) begin
                    cnt    <= '0;
                    out_q  <= ~out_q;
                    tick_q <= 1'b1;
                    if (pend) begin
                        act <= shd;
                    end
                end else begin
                    cnt    <= cnt + 1'b1;
                    tick_q <= 1'b0;
                end
                // A write landing on the wrap edge waits for the following wrap.
                if (hit) begin
                    shd  <= wr_div;
                    pend <= 1'b1;
                end else if (wrap) begin
                    pend <= 1'b0;
                end
            end
        end

        assign clk_out[i] = out_q;
        assign tick[i]    = tick_q;
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: directed scenarios plus randomized
// traffic compared against a per-channel half-period reference model.
module tb_clk_divider_multi;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int DD = 3;
    localparam int CW = 2;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [W-1:0]  wr_div;
    logic [CH-1:0] ch_en;
    logic          sync;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: divisor in force, queued divisor, and position in half-period.
    int m_act [CH];
    int m_shd [CH];
    int m_pos [CH];
    bit m_pend[CH];
    bit m_lvl [CH];
    bit m_tk  [CH];

    clk_divider_multi #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .DEFAULT_DIV(DD)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .ch_en  (ch_en),
        .sync   (sync),
        .clk_out(clk_out),
        .tick   (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_act[i]  = DD;
            m_shd[i]  = DD;
            m_pos[i]  = 0;
            m_pend[i] = 1'b0;
            m_lvl[i]  = 1'b0;
            m_tk[i]   = 1'b0;
        end
    endfunction

    // Half-period length is max(act,1); the output flips once that many enabled
    // edges have been spent in the current half-period.
    function automatic void model_edge();
        for (int i = 0; i < CH; i++) begin
            bit wr_here;
            int half;
            wr_here = wr_en && (int'(wr_ch) == i);
            half    = (m_act[i] == 0) ? 1 : m_act[i];
            if (sync) begin
                m_pos[i] = 0;
                m_lvl[i] = 1'b0;
                m_tk[i]  = 1'b0;
                if (wr_here)        m_act[i] = int'(wr_div);
                else if (m_pend[i]) m_act[i] = m_shd[i];
                m_pend[i] = 1'b0;
            end else if (!ch_en[i]) begin
                m_tk[i] = 1'b0;
                if (wr_here) begin
                    m_act[i]  = int'(wr_div);
                    m_pend[i] = 1'b0;
                end
            end else begin
                if (m_pos[i] + 1 >= half) begin
                    m_pos[i] = 0;
                    m_lvl[i] = ~m_lvl[i];
                    m_tk[i]  = 1'b1;
                    if (m_pend[i]) m_act[i] = m_shd[i];
                    m_pend[i] = 1'b0;
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                    m_tk[i]  = 1'b0;
                end
                if (wr_here) begin
                    m_shd[i]  = int'(wr_div);
                    m_pend[i] = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [CH-1:0] exp_out();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_lvl[i];
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_tick();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_tk[i];
        return v;
    endfunction

    task automatic step();
        @(posedge clk_in);
        model_edge();
        cyc++;
        #1;
        check("model_clk_out", clk_out, exp_out());
        check("model_tick", tick, exp_tick());
    endtask

    initial begin
        logic held;
        logic lv;

        rst    = 1'b1;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_div = '0;
        ch_en  = '1;
        sync   = 1'b0;
        model_reset();
        #12;
        check("reset_clk_out", clk_out, 0);
        check("reset_tick", tick, 0);

        @(negedge clk_in);
        rst = 1'b0;
        cyc = 0;

        // Default divisor 3: rise at edge 3, fall at edge 6.
        for (int e = 1; e <= 7; e++) begin
            step();
            check("first_wave_out", clk_out[0], (e >= 3 && e <= 5));
            check("first_wave_tick", tick[0], (e == 3 || e == 6));
        end

        // Write 5 to channel 1 mid half-period; the 6->9 half stays 3, then 5s.
        wr_en  = 1'b1;
        wr_ch  = 2'd1;
        wr_div = 8'd5;
        step();
        wr_en = 1'b0;
        for (int e = 9; e <= 20; e++) begin
            step();
            check("shadow_tick", tick[1], (cyc == 9 || cyc == 14 || cyc == 19));
        end

        // Freeze channel 2 with cnt=1 for 10 cycles, then resume.
        step();
        step();
        held  = m_lvl[2];
        ch_en = 3'b011;
        for (int k = 0; k < 10; k++) begin
            step();
            check("freeze_out", clk_out[2], held);
            check("freeze_tick", tick[2], 0);
        end
        ch_en = '1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("resume_tick", tick[2], (k == 1));
        end

        // Divisors 2 and 7 queued, then sync restarts both phase-aligned.
        wr_en  = 1'b1;
        wr_ch  = 2'd0;
        wr_div = 8'd2;
        step();
        wr_ch  = 2'd1;
        wr_div = 8'd7;
        step();
        wr_en = 1'b0;
        sync  = 1'b1;
        step();
        sync = 1'b0;
        check("sync_out", clk_out, 0);
        check("sync_tick", tick, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("sync_ch0", clk_out[0], ((k / 2) % 2));
            check("sync_ch1", clk_out[1], (k >= 7));
        end

        // Divisor 0 behaves as 1; a write to channel index 3 is dropped.
        ch_en  = 3'b011;
        wr_en  = 1'b1;
        wr_ch  = 2'd2;
        wr_div = 8'd0;
        step();
        wr_ch  = 2'd3;
        wr_div = 8'd6;
        step();
        wr_en = 1'b0;
        ch_en = '1;
        lv    = m_lvl[2];
        for (int k = 0; k < 6; k++) begin
            step();
            lv = ~lv;
            check("div0_out", clk_out[2], lv);
            check("div0_tick", tick[2], 1);
        end

        // Async reset mid-cycle with a pending write on channel 0.
        wr_en  = 1'b1;
        wr_ch  = 2'd0;
        wr_div = 8'd6;
        step();
        wr_en = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out", clk_out, 0);
        check("async_rst_tick", tick, 0);
        model_reset();
        #2;
        rst = 1'b0;
        cyc = 0;
        for (int e = 1; e <= 7; e++) begin
            step();
            check("post_rst_out", clk_out[0], (e >= 3 && e <= 5));
            check("post_rst_tick", tick[0], (e == 3 || e == 6));
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            wr_en  = ($urandom_range(0, 3) == 0);
            wr_ch  = CW'($urandom_range(0, 3));
            wr_div = W'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) ch_en = CH'($urandom);
            sync = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_divider_multi.md
CLK_DIVIDER_MULTI -- requirements
Module: clk_divider_multi

Interface
REQ-001 The module SHALL have parameter CHANNELS, default 4, meaning the number of independent divider channels (1..16).
REQ-002 The module SHALL have parameter WIDTH, default 32, meaning the bit width of the counters and divisors.
REQ-003 The module SHALL have parameter DEFAULT_DIV, default 50_000_000, meaning the half-period divisor loaded into every channel at reset; it must fit in WIDTH bits.
REQ-004 The module SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port wr_en, input, 1 bit: divisor write strobe.
REQ-007 The module SHALL have port wr_ch, input, max(1,clog2(CHANNELS)) bits: target channel of the write.
REQ-008 The module SHALL have port wr_div, input, WIDTH bits: new half-period divisor.
REQ-009 The module SHALL have port ch_en, input, CHANNELS bits: per-channel run enable.
REQ-010 The module SHALL have port sync, input, 1 bit: phase-align restart of all channels.
REQ-011 The module SHALL have port clk_out, output, CHANNELS bits: registered divided clocks.
REQ-012 The module SHALL have port tick, output, CHANNELS bits: registered one-cycle pulse on each clk_out toggle.

Function
REQ-013 Each channel SHALL hold an active divisor (act), a shadow divisor (shd), a pending flag and a counter (cnt).
REQ-014 An effective divisor SHALL be computed as act, or 1 when act is 0.
REQ-015 When ch_en[i]=1 and sync=0, cnt SHALL increment by 1 per cycle until it equals effective divisor - 1.
REQ-016 On that cycle, cnt SHALL return to 0, clk_out[i] SHALL invert, and tick[i] SHALL be 1 for exactly the next cycle.
REQ-017 As a result, clk_out period SHALL be 2 x effective divisor cycles with a 50% duty cycle.
REQ-018 When ch_en[i]=0, cnt and clk_out[i] SHALL hold their values and tick[i] SHALL be 0.
REQ-019 When ch_en[i] rises again, the channel SHALL resume counting from the held cnt.
REQ-020 When wr_en=1 with wr_ch < CHANNELS, wr_div SHALL be stored in shd[wr_ch] and pending SHALL be set.
REQ-021 When wr_ch >= CHANNELS, the write SHALL be ignored.
REQ-022 A pending shadow SHALL be copied to act on the cycle the channel wraps, and pending SHALL clear; it therefore governs the next half-period and no output glitch occurs.
REQ-023 When a channel is disabled, a write SHALL be copied to act immediately on the following edge.
REQ-024 When a write and a wrap occur in the same cycle, the new value SHALL be stored in shd with pending set, and the previous shd (if pending) SHALL be applied at that wrap.
REQ-025 When a second write arrives before a wrap, it SHALL overwrite shd; only the last value is applied.
REQ-026 When sync=1, every channel SHALL set cnt=0 and clk_out=0, and tick SHALL be 0.
REQ-027 When sync=1, every pending shd SHALL be copied to act; a write in the same cycle SHALL go directly to act.
REQ-028 sync SHALL take priority over ch_en and over wrap.
REQ-029 When effective divisor = 1, clk_out SHALL toggle every cycle and tick SHALL stay at 1 continuously.
REQ-030 When act is lowered below the current cnt+1, cnt SHALL still wrap correctly: the wrap condition is cnt >= effective divisor - 1.

Reset
REQ-031 While rst=1, asynchronously, all cnt SHALL be 0, all clk_out SHALL be 0, all tick SHALL be 0, all act and shd SHALL be DEFAULT_DIV, and all pending flags SHALL be 0.
REQ-032 Reset asserted mid-period SHALL abort the period and discard pending writes.
REQ-033 The first wrap after release SHALL occur DEFAULT_DIV cycles after the first enabled edge.

Verification
REQ-034 Bench: DEFAULT_DIV=3, ch_en=all 1 after reset -> clk_out[0] rises on cycle 3, falls on cycle 6, with tick high the cycle after each edge.
REQ-035 Bench: mid-half-period, write div=5 to channel 1 -> the current half-period stays 3 cycles, and the next half-periods are 5.
REQ-036 Bench: ch_en[2]=0 for 10 cycles mid-count -> clk_out[2] and cnt freeze, tick[2]=0, and counting resumes with the remaining count.
REQ-037 Bench: channels with divisors 2 and 7, sync pulse -> both clk_out=0 and cnt=0 next cycle, with rising edges at cycles 2 and 7 after sync.
REQ-038 Bench: write wr_div=0 and write wr_ch=CHANNELS -> channel toggles every cycle, and the out-of-range write changes nothing.
REQ-039 Bench: rst pulse asserted between clock edges with pending write -> outputs 0 immediately, and after release period = 2xDEFAULT_DIV.
